// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, shares the single ROM read port
// between fetch and a debug reader, and buffers fetched words in a 2-entry queue.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_data
);

    typedef enum logic {
        DBG_IDLE = 1'b0,
        DBG_ACK  = 1'b1
    } dbg_state_t;

    localparam logic LAST_FETCH = 1'b0;
    localparam logic LAST_DBG   = 1'b1;

    logic [31:0]      pc_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             last_reg;
    dbg_state_t       dbg_state_reg;
    logic             dbg_ack_reg;
    logic [31:0]      dbg_data_reg;
    logic [1:0][31:0] q_inst_reg;
    logic [1:0][31:0] q_pc_reg;
    logic [1:0][31:0] q_inst_next;
    logic [1:0][31:0] q_pc_next;

    logic       pop;
    logic       fetch_want;
    logic       dbg_want;
    logic       contended;
    logic       dbg_grant;
    logic       fetch_grant;
    logic [1:0] wr_idx;

    // Requests are masked while reset is held so rom_addr shows the reset PC
    // even if a debug request is pending.
    assign pop         = (count_reg != 2'd0) & inst_ready;
    assign fetch_want  = rst_n & fetch_en & ~redir_valid & ((count_reg != 2'd2) | pop);
    assign dbg_want    = rst_n & dbg_req & (dbg_state_reg == DBG_IDLE);
    assign contended   = fetch_want & dbg_want;
    assign dbg_grant   = dbg_want & (~fetch_want | (last_reg == LAST_FETCH));
    assign fetch_grant = fetch_want & ~dbg_grant;

    assign rom_addr = dbg_grant ? dbg_addr : pc_reg;

    // Slot the new word lands in once the (optional) pop has shifted the queue.
    assign wr_idx     = count_reg - {1'b0, pop};
    assign count_next = redir_valid ? 2'd0 : (wr_idx + {1'b0, fetch_grant});

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [31:0] keep_inst;
            logic [31:0] keep_pc;
            if (gi == 0) begin : g_head
                assign keep_inst = pop ? q_inst_reg[1] : q_inst_reg[0];
                assign keep_pc   = pop ? q_pc_reg[1]   : q_pc_reg[0];
            end else begin : g_tail
                assign keep_inst = q_inst_reg[gi];
                assign keep_pc   = q_pc_reg[gi];
            end
            assign q_inst_next[gi] = (fetch_grant && (wr_idx == 2'(gi))) ? rom_inst : keep_inst;
            assign q_pc_next[gi]   = (fetch_grant && (wr_idx == 2'(gi))) ? pc_reg   : keep_pc;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= RESET_PC;
            count_reg  <= 2'd0;
            q_inst_reg <= '0;
            q_pc_reg   <= '0;
        end else begin
            count_reg  <= count_next;
            q_inst_reg <= q_inst_next;
            q_pc_reg   <= q_pc_next;
            if (redir_valid) begin
                pc_reg <= redir_pc;
            end else if (fetch_grant) begin
                pc_reg <= pc_reg + 32'd4;
            end
        end
    end

    // Round-robin memory: only contended grants move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= LAST_FETCH;
        end else if (contended) begin
            last_reg <= dbg_grant ? LAST_DBG : LAST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_state_reg <= DBG_IDLE;
            dbg_ack_reg   <= 1'b0;
            dbg_data_reg  <= 32'd0;
        end else begin
            case (dbg_state_reg)
                DBG_IDLE: begin
                    if (dbg_grant) begin
                        dbg_state_reg <= DBG_ACK;
                        dbg_ack_reg   <= 1'b1;
                        dbg_data_reg  <= rom_inst;
                    end
                end
                DBG_ACK: begin
                    dbg_state_reg <= DBG_IDLE;
                    dbg_ack_reg   <= 1'b0;
                end
                default: begin
                    dbg_state_reg <= DBG_IDLE;
                    dbg_ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign inst_valid = (count_reg != 2'd0);
    assign inst       = q_inst_reg[0];
    assign inst_pc    = q_pc_reg[0];
    assign dbg_ack    = dbg_ack_reg;
    assign dbg_data   = dbg_data_reg;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: streaming, backpressure, redirect, debug
// arbitration, fetch disable and asynchronous reset.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;

    ifetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_ack    (dbg_ack),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM image; unlisted addresses return a recognisable address-derived word.
    always_comb begin
        case (rom_addr)
            32'h0000_0000: rom_inst = 32'h0000_0000;
            32'h0000_0004: rom_inst = 32'h1400_1863;
            32'h0000_0008: rom_inst = 32'h4000_0423;
            default:       rom_inst = rom_addr ^ 32'hA5A5_0000;
        endcase
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two cycles, then releases it just after a rising edge,
    // so the next rising edge is cycle 0.
    task automatic do_reset(input logic fen, input logic rdy);
        rst_n       = 1'b0;
        redir_valid = 1'b0;
        dbg_req     = 1'b0;
        step();
        step();
        fetch_en   = fen;
        inst_ready = rdy;
        rst_n      = 1'b1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        inst_ready  = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        dbg_req     = 1'b1;
        dbg_addr    = 32'h8;
        step();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_dbg_ack: got %b expected 0", dbg_ack); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg_data: got %h expected 00000000", dbg_data); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00000000", rom_addr); end
        $display("test_reset done");
    endtask

    task automatic test_stream;
        do_reset(1'b1, 1'b1);
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL stream_addr0: got %h expected 00000000", rom_addr); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0) begin errors++; $display("FAIL stream_c1: got v=%b pc=%h inst=%h expected v=1 pc=00000000 inst=00000000", inst_valid, inst_pc, inst); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== 32'h1400_1863) begin errors++; $display("FAIL stream_c2: got v=%b pc=%h inst=%h expected v=1 pc=00000004 inst=14001863", inst_valid, inst_pc, inst); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'h4000_0423) begin errors++; $display("FAIL stream_c3: got v=%b pc=%h inst=%h expected v=1 pc=00000008 inst=40000423", inst_valid, inst_pc, inst); end
        $display("test_stream done");
    endtask

    task automatic test_backpressure;
        do_reset(1'b1, 1'b0);
        step();
        step();
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=00000000", inst_valid, inst_pc); end
        checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL bp_rom_addr_hold: got %h expected 00000008", rom_addr); end
        inst_ready = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== 32'h1400_1863) begin errors++; $display("FAIL bp_drain1: got v=%b pc=%h inst=%h expected v=1 pc=00000004 inst=14001863", inst_valid, inst_pc, inst); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'h4000_0423) begin errors++; $display("FAIL bp_drain2: got v=%b pc=%h inst=%h expected v=1 pc=00000008 inst=40000423", inst_valid, inst_pc, inst); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin errors++; $display("FAIL bp_no_gap: got v=%b pc=%h expected v=1 pc=0000000c", inst_valid, inst_pc); end
        $display("test_backpressure done");
    endtask

    task automatic test_redirect;
        do_reset(1'b1, 1'b0);
        step();
        step();
        redir_valid = 1'b1;
        redir_pc    = 32'h20;
        step();
        redir_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got v=%b expected 0", inst_valid); end
        checks++; if (rom_addr !== 32'h20) begin errors++; $display("FAIL redir_addr: got %h expected 00000020", rom_addr); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== 32'hA5A5_0020) begin errors++; $display("FAIL redir_target: got v=%b pc=%h inst=%h expected v=1 pc=00000020 inst=a5a50020", inst_valid, inst_pc, inst); end
        $display("test_redirect done");
    endtask

    task automatic test_debug;
        do_reset(1'b1, 1'b1);
        dbg_req  = 1'b1;
        dbg_addr = 32'h8;
        #1;
        checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL dbg_first_grant: got %h expected 00000008", rom_addr); end
        step();
        checks++; if (dbg_ack !== 1'b1 || dbg_data !== 32'h4000_0423) begin errors++; $display("FAIL dbg_ack1: got ack=%b data=%h expected ack=1 data=40000423", dbg_ack, dbg_data); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL dbg_no_fetch: got v=%b expected 0", inst_valid); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL dbg_ack_cycle_fetch: got %h expected 00000000", rom_addr); end
        step();
        checks++; if (dbg_ack !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL dbg_after_ack: got ack=%b v=%b pc=%h expected ack=0 v=1 pc=00000000", dbg_ack, inst_valid, inst_pc); end
        checks++; if (rom_addr !== 32'h4) begin errors++; $display("FAIL dbg_rr_fetch: got %h expected 00000004", rom_addr); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL dbg_fetch4: got v=%b pc=%h expected v=1 pc=00000004", inst_valid, inst_pc); end
        checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL dbg_rr_debug: got %h expected 00000008", rom_addr); end
        step();
        dbg_req = 1'b0;
        checks++; if (dbg_ack !== 1'b1 || dbg_data !== 32'h4000_0423) begin errors++; $display("FAIL dbg_ack2: got ack=%b data=%h expected ack=1 data=40000423", dbg_ack, dbg_data); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL dbg_drained: got v=%b expected 0", inst_valid); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'h4000_0423) begin errors++; $display("FAIL dbg_fetch8: got v=%b pc=%h inst=%h expected v=1 pc=00000008 inst=40000423", inst_valid, inst_pc, inst); end
        $display("test_debug done");
    endtask

    task automatic test_fetch_disable;
        do_reset(1'b1, 1'b0);
        step();
        step();
        fetch_en   = 1'b0;
        inst_ready = 1'b1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL fd_full_head: got v=%b pc=%h expected v=1 pc=00000000", inst_valid, inst_pc); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL fd_drain: got v=%b pc=%h expected v=1 pc=00000004", inst_valid, inst_pc); end
        step();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fd_empty: got v=%b expected 0", inst_valid); end
        checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL fd_pc_hold: got %h expected 00000008", rom_addr); end
        dbg_req  = 1'b1;
        dbg_addr = 32'h4;
        step();
        dbg_req = 1'b0;
        checks++; if (dbg_ack !== 1'b1 || dbg_data !== 32'h1400_1863) begin errors++; $display("FAIL fd_dbg: got ack=%b data=%h expected ack=1 data=14001863", dbg_ack, dbg_data); end
        step();
        checks++; if (dbg_ack !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 32'h8) begin errors++; $display("FAIL fd_idle: got ack=%b v=%b addr=%h expected ack=0 v=0 addr=00000008", dbg_ack, inst_valid, rom_addr); end
        $display("test_fetch_disable done");
    endtask

    task automatic test_async_reset;
        do_reset(1'b1, 1'b0);
        step();
        step();
        dbg_req  = 1'b1;
        dbg_addr = 32'h8;
        #1;
        checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL ar_grant: got %h expected 00000008", rom_addr); end
        step();
        checks++; if (dbg_ack !== 1'b1 || inst_valid !== 1'b1) begin errors++; $display("FAIL ar_pending: got ack=%b v=%b expected ack=1 v=1", dbg_ack, inst_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dbg_ack !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 32'h0) begin errors++; $display("FAIL ar_async: got ack=%b v=%b addr=%h expected ack=0 v=0 addr=00000000", dbg_ack, inst_valid, rom_addr); end
        dbg_req    = 1'b0;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0) begin errors++; $display("FAIL ar_restart: got v=%b pc=%h inst=%h expected v=1 pc=00000000 inst=00000000", inst_valid, inst_pc, inst); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL ar_restart2: got v=%b pc=%h expected v=1 pc=00000004", inst_valid, inst_pc); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_debug();
        test_fetch_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that sequences the instruction ROM and shares its single combinational read port between the CPU fetch path and a debug read port. It owns the PC and redirects to a branch/jump target, and it buffers fetched words in a 2-entry queue with a valid/ready handshake toward decode. It sits between the PC/branch logic, the instruction ROM (`a`/`inst`) and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  1 = fetch allowed; 0 = no new fetches, queue still drains.
- `redir_valid`  in  1  redirect request, single cycle.
- `redir_pc`  in  32  redirect target, word aligned.
- `rom_addr`  out  32  byte address to ROM `a`; combinational.
- `rom_inst`  in  32  ROM `inst`; valid in the same cycle as `rom_addr`.
- `inst_valid`  out  1  queue head valid.
- `inst`  out  32  queue head instruction.
- `inst_pc`  out  32  queue head PC.
- `inst_ready`  in  1  decode accepts the head.
- `dbg_req`  in  1  debug read request, level; held until `dbg_ack`.
- `dbg_addr`  in  32  debug byte address.
- `dbg_ack`  out  1  one-cycle pulse; `dbg_data` valid.
- `dbg_data`  out  32  registered debug read data.

## Operation
- One ROM access per cycle, owned by either the fetch requester or the debug requester.
- Fetch wants the port when `fetch_en` is 1, `redir_valid` is 0, and (count < 2 or pop). Pop is `inst_valid & inst_ready`.
- Debug wants the port when `dbg_req` is 1 and the debug FSM is in IDLE.
- Arbitration:
  - If only one requester wants the port, it gets it.
  - If both want it, round-robin: the requester not served at the last contended grant wins. The `last` bit resets to "fetch", so debug wins the first contention.
- `rom_addr` is `dbg_addr` when debug is granted, and `pc` otherwise.
- Fetch grant: enqueue {`pc`, `rom_inst`} and set `pc <= pc + 4` (mod 2^32). Pop and enqueue may occur in the same cycle.
- Queue: 2-entry FIFO in order. `inst`/`inst_pc` always show the head. No enqueue when full unless a pop occurs in the same cycle.
- Redirect (`redir_valid`=1):
  - Flush the queue (count <= 0) and set `pc <= redir_pc`.
  - No fetch is issued that cycle. A pop in the same cycle counts as consumed.
  - Debug may still be granted in a redirect cycle.
- Debug FSM:
  - IDLE -> ACK on debug grant, with `dbg_data <= rom_inst` captured in the grant cycle.
  - ACK -> IDLE unconditionally after one cycle. `dbg_ack` = 1 in ACK.
  - `dbg_req` is ignored in ACK, so there is no double grant. The requester lowers it or presents a new address there.
- `fetch_en`=0 does not stop debug grants, pops or redirects.

## Timing
- Reset (async assert, sync-released by the top) sets:
  - `pc`=`RESET_PC`, count=0, `last`=fetch, debug FSM=IDLE.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0, `dbg_ack`=0, `dbg_data`=0.
  - `rom_addr`=`RESET_PC`.
- Fetch latency: a grant in cycle N gives `inst_valid`=1 in N+1 (empty queue case).
- Sustained throughput is 1 instruction/cycle with `inst_ready`=1 and no debug traffic.
- Redirect in cycle N: `inst_valid`=0 in N+1; the target is fetched in N+1 and shown in N+2.
- Debug: a grant in N gives `dbg_ack`=1 with data in N+1. Minimum debug period is 2 cycles.
- Full queue with no pop: `pc` and `rom_addr` hold, and nothing is lost.
- Reset asserted mid-operation clears the queue and aborts a pending `dbg_ack` immediately (asynchronously).

## Test plan
Each scenario uses the current ROM image: 0x0 -> 0x00000000, 0x4 -> 0x14001863, 0x8 -> 0x40000423.

- Release reset with `fetch_en`=1, `inst_ready`=1 -> `inst_pc` is 0x0, 0x4, 0x8 on consecutive cycles starting at cycle 1. `inst` is 0x00000000, 0x14001863, 0x40000423.
- Hold `inst_ready`=0 -> after 2 fetches `inst_valid` stays 1, the head is 0x0 and `rom_addr` holds 0x8. Then raise `inst_ready` -> 0x0, 0x4, 0x8 in order, with no gap after the drain.
- With the queue full, pulse `redir_valid` with `redir_pc`=0x20 -> `inst_valid`=0 the next cycle, and the following cycle shows `inst_pc`=0x20.
- With fetch active, hold `dbg_req`=1 and `dbg_addr`=0x8:
  - Debug is granted first, then `dbg_ack`=1 with `dbg_data`=0x40000423.
  - The next contended grant goes to fetch.
  - No fetch entry is lost or duplicated.
- Set `fetch_en`=0 with the queue holding 2 entries and `inst_ready`=1 -> the queue drains in 2 cycles, then `inst_valid`=0 and `pc` is unchanged. A debug read is still acked.
- Assert `rst_n`=0 during a debug grant with the queue full -> `dbg_ack`=0, `inst_valid`=0 and `rom_addr`=0x0 without waiting for a clock edge. After release, fetching restarts at 0x0.
